// File: rtl/keypad_emulator_if.sv
// Keypad emulator interface: press/release request handshake plus the column-strobe / row-line scan bus.
// The emulator sits on the slave side; a bench or self-test controller drives the master side.
interface keypad_emulator_if;
  logic       press_req;
  logic [3:0] key_idx;
  logic       release_req;
  logic [2:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;
  logic       err;
  logic       contact;

  modport master (
    output press_req,
    output key_idx,
    output release_req,
    output col,
    input  row,
    input  busy,
    input  done,
    input  err,
    input  contact
  );

  modport slave (
    input  press_req,
    input  key_idx,
    input  release_req,
    input  col,
    output row,
    output busy,
    output done,
    output err,
    output contact
  );
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: behaves like one closed switch of a 4x3 membrane keypad on the column-scan bus.
// Define KEYPAD_BOUNCE_EN to model contact bounce on press and release; otherwise the switch is clean.
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 16,
  parameter int BOUNCE_CYCLES  = 4,
  parameter int BOUNCE_TOGGLES = 3
) (
  input logic              clk,
  input logic              reset,
  keypad_emulator_if.slave kp
);

  localparam int SEG_MAX = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int SEG_W   = $clog2(SEG_MAX + 1);
  localparam logic [SEG_W-1:0] HOLD_LAST = SEG_W'(HOLD_CYCLES - 1);

`ifdef KEYPAD_BOUNCE_EN
  localparam int TOG_W = $clog2(2 * BOUNCE_TOGGLES) + 1;
  localparam logic [SEG_W-1:0] BOUNCE_LAST = SEG_W'(BOUNCE_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_LAST    = TOG_W'(2 * BOUNCE_TOGGLES - 1);
`endif

  if (HOLD_CYCLES < 1 || BOUNCE_CYCLES < 1 || BOUNCE_TOGGLES < 1) begin : g_bad_params
    $error("keypad_emulator: HOLD_CYCLES, BOUNCE_CYCLES and BOUNCE_TOGGLES must all be >= 1");
  end

`ifdef KEYPAD_BOUNCE_EN
  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             contact_q;
  logic [1:0]       row_sel;
  logic [1:0]       col_sel;
  logic [SEG_W-1:0] seg_cnt;
`ifdef KEYPAD_BOUNCE_EN
  logic [TOG_W-1:0] tog_cnt;
`endif

  logic [1:0] key_row;
  logic [1:0] key_col;
  logic       key_valid;
  logic [3:0] row_n;

  always_comb begin
    key_row   = 2'(kp.key_idx / 4'd3);
    key_col   = 2'(kp.key_idx % 4'd3);
    key_valid = (kp.key_idx <= 4'd11);
  end

  // The closed contact only shorts its row while the scanner strobes the latched column.
  always_comb begin
    row_n = 4'b1111;
    if (contact_q && !kp.col[col_sel]) begin
      row_n[row_sel] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      contact_q <= 1'b0;
      row_sel   <= 2'd0;
      col_sel   <= 2'd0;
      seg_cnt   <= '0;
`ifdef KEYPAD_BOUNCE_EN
      tog_cnt   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (kp.press_req) begin
            if (key_valid) begin
              row_sel   <= key_row;
              col_sel   <= key_col;
              busy_q    <= 1'b1;
              contact_q <= 1'b1;
              seg_cnt   <= '0;
`ifdef KEYPAD_BOUNCE_EN
              tog_cnt   <= '0;
              state     <= BOUNCE_IN;
`else
              state     <= HOLD;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        BOUNCE_IN: begin
          if (kp.release_req) begin
            state     <= BOUNCE_OUT;
            contact_q <= 1'b0;
            seg_cnt   <= '0;
            tog_cnt   <= '0;
          end else if (seg_cnt == BOUNCE_LAST) begin
            seg_cnt <= '0;
            if (tog_cnt == TOG_LAST) begin
              state     <= HOLD;
              contact_q <= 1'b1;
              tog_cnt   <= '0;
            end else begin
              tog_cnt   <= tog_cnt + 1'b1;
              contact_q <= ~contact_q;
            end
          end else begin
            seg_cnt <= seg_cnt + 1'b1;
          end
        end
`endif
        HOLD: begin
          if (kp.release_req || seg_cnt == HOLD_LAST) begin
            seg_cnt   <= '0;
            contact_q <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
            tog_cnt   <= '0;
            state     <= BOUNCE_OUT;
`else
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
`endif
          end else begin
            seg_cnt <= seg_cnt + 1'b1;
          end
        end
`ifdef KEYPAD_BOUNCE_EN
        // Release bounce starts open and ends closed; the final edge lands in IDLE open.
        BOUNCE_OUT: begin
          if (seg_cnt == BOUNCE_LAST) begin
            seg_cnt <= '0;
            if (tog_cnt == TOG_LAST) begin
              state     <= IDLE;
              contact_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              tog_cnt   <= '0;
            end else begin
              tog_cnt   <= tog_cnt + 1'b1;
              contact_q <= ~contact_q;
            end
          end else begin
            seg_cnt <= seg_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign kp.row     = row_n;
  assign kp.busy    = busy_q;
  assign kp.done    = done_q;
  assign kp.err     = err_q;
  assign kp.contact = contact_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
module tb_keypad_emulator;

  logic clk;
  logic reset;

  keypad_emulator_if kp();

  keypad_emulator #(
    .HOLD_CYCLES   (8),
    .BOUNCE_CYCLES (2),
    .BOUNCE_TOGGLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Expected vector layout: {busy, contact, done, err, row[3:0]}
  string      nameQ[$];
  int         cycQ[$];
  logic [7:0] vecQ[$];

  task automatic checkOutput(input string name, input int cyc, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got busy/contact/done/err/row=%b required %b", name, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] expRow(input logic c, input logic [3:0] key, input logic [2:0] colv);
    int r;
    int cc;
    logic [3:0] rv;
    r  = int'(key) / 3;
    cc = int'(key) % 3;
    rv = 4'b1111;
    if (c && !colv[cc]) rv[r] = 1'b0;
    return rv;
  endfunction

  function automatic logic [2:0] colFor(input int mode, input logic [2:0] fixedCol, input int i);
    logic [2:0] v;
    v = fixedCol;
    if (mode == 1) begin
      case (i % 3)
        0:       v = 3'b110;
        1:       v = 3'b101;
        default: v = 3'b011;
      endcase
    end
    return v;
  endfunction

  // Monitor: every negedge with a queued expectation is a comparison; stray pulses are flagged too.
  always @(negedge clk) begin
    if (vecQ.size() > 0) begin
      checkOutput(nameQ.pop_front(), cycQ.pop_front(), {kp.busy, kp.contact, kp.done, kp.err, kp.row},
                  vecQ.pop_front());
    end else if (reset && (kp.done || kp.err)) begin
      checkOutput("unexpected_pulse", 0, {kp.busy, kp.contact, kp.done, kp.err, kp.row},
                  {kp.busy, kp.contact, 2'b00, kp.row});
    end
  end

  // Called at posedge+1; cycle i spans the following negedge. Press is issued in cycle 0.
  task automatic applyStimulus(input string name, input logic [3:0] key, input int n,
                               input logic [63:0] cPat, input logic [63:0] bPat,
                               input logic [63:0] dPat, input logic [63:0] ePat,
                               input int colMode, input logic [2:0] fixedCol,
                               input int relAt, input int pressAt, input logic [3:0] pressKey);
    for (int i = 0; i < n; i++) begin
      nameQ.push_back(name);
      cycQ.push_back(i);
      vecQ.push_back({bPat[i], cPat[i], dPat[i], ePat[i], expRow(cPat[i], key, colFor(colMode, fixedCol, i))});
    end
    for (int i = 0; i < n; i++) begin
      kp.press_req   = (i == 0) || (i == pressAt);
      kp.key_idx     = (i == pressAt) ? pressKey : key;
      kp.release_req = (i == relAt);
      kp.col         = colFor(colMode, fixedCol, i);
      @(posedge clk);
      #1;
    end
    kp.press_req   = 1'b0;
    kp.release_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset          = 1'b0;
    kp.press_req   = 1'b0;
    kp.key_idx     = 4'd0;
    kp.release_req = 1'b0;
    kp.col         = 3'b000;
    #1;
    checkOutput("reset_state", 0, {kp.busy, kp.contact, kp.done, kp.err, kp.row}, 8'b0000_1111);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

`ifdef KEYPAD_BOUNCE_EN
    // Bounce-in 1,1,0,0,1,1,0,0; hold 8x1; bounce-out 0,0,1,1,0,0,1,1; then IDLE with done.
    applyStimulus("bounce_key0", 4'd0, 27,
                  64'(27'b0_0_11_00_11_00_11111111_00_11_00_11_0),
                  64'(27'b0_0_111111111111111111111111_0),
                  64'(1) << 25, 64'd0, 0, 3'b110, -1, -1, 4'd0);
`else
    // Clean press of key 5 (row 1, col 2): contact in cycles 1..8, done in cycle 9.
    applyStimulus("press_key5", 4'd5, 11, 64'h1FE, 64'h1FE, 64'h200, 64'd0, 0, 3'b011, -1, -1, 4'd0);
    // Rotating columns; release_req alongside the press is ignored in IDLE.
    applyStimulus("rotate_key5", 4'd5, 11, 64'h1FE, 64'h1FE, 64'h200, 64'd0, 1, 3'b000, 0, -1, 4'd0);
    // Abort three cycles into HOLD; a press of key 11 mid-sequence must be ignored.
    applyStimulus("release_abort", 4'd5, 6, 64'h00E, 64'h00E, 64'h010, 64'd0, 0, 3'b011, 3, 2, 4'd11);
`endif

    applyStimulus("reject_key12", 4'd12, 3, 64'd0, 64'd0, 64'd0, 64'h2, 0, 3'b000, -1, -1, 4'd0);
    applyStimulus("reject_key15", 4'd15, 3, 64'd0, 64'd0, 64'd0, 64'h2, 0, 3'b000, -1, -1, 4'd0);

    // Reset mid-press: outputs must clear before any clock edge.
    kp.col       = 3'b011;
    kp.key_idx   = 4'd5;
    kp.press_req = 1'b1;
    @(posedge clk);
    #1;
    kp.press_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("before_reset", 0, {kp.busy, kp.contact, kp.done, kp.err, kp.row}, 8'b1100_1101);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 0, {kp.busy, kp.contact, kp.done, kp.err, kp.row}, 8'b0000_1111);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nameQ.push_back("after_reset");
      cycQ.push_back(i);
      vecQ.push_back(8'b0000_1111);
    end
    repeat (4) @(posedge clk);
    #1;

    if (vecQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", vecQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
